trigger_pulse_gen: RTL and testbench

//  Output-side partner of the trigger delay path. Takes the single-cycle delayed trigger

---
 rtl/trigger_pulse_gen.sv | 158 +++++++++++++++
 tb/tb_trigger_pulse_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/trigger_pulse_gen.sv
// Burst pulse shaper behind the trigger delay stage: programmable width, gap and count.
// Build option: define TRIGGER_PULSE_GEN_RETRIGGER_EN to let a trigger restart a running burst.
module trigger_pulse_gen #(
  parameter int CNT_BITS   = 32,
  parameter int BURST_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trigger_pulse,
  input  logic [CNT_BITS-1:0]   pulse_width,
  input  logic [CNT_BITS-1:0]   pulse_gap,
  input  logic [BURST_BITS-1:0] pulse_count,
  input  logic                  cfg_update,
  output logic                  trigger_out,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

  localparam logic [CNT_BITS-1:0]   CNT_ONE   = CNT_BITS'(1);
  localparam logic [BURST_BITS-1:0] BURST_ONE = BURST_BITS'(1);

  state_t                state, state_nx;
  logic [CNT_BITS-1:0]   cnt, cnt_nx;
  logic [BURST_BITS-1:0] burst, burst_nx;
  logic                  finish;
  logic                  restart;

  logic [CNT_BITS-1:0]   sh_width, sh_gap, pend_width, pend_gap;
  logic [BURST_BITS-1:0] sh_count, pend_count;
  logic                  pend;

  logic [CNT_BITS-1:0]   in_width, in_gap, eff_width;
  logic [BURST_BITS-1:0] in_count, eff_count;

  // Zero in any field means one; storing the clamped value keeps the counters simple.
  assign in_width  = (pulse_width == '0) ? CNT_ONE : pulse_width;
  assign in_gap    = (pulse_gap == '0) ? CNT_ONE : pulse_gap;
  assign in_count  = (pulse_count == '0) ? BURST_ONE : pulse_count;
  assign eff_width = (state == IDLE && cfg_update) ? in_width : sh_width;
  assign eff_count = (state == IDLE && cfg_update) ? in_count : sh_count;

`ifdef TRIGGER_PULSE_GEN_RETRIGGER_EN
  assign restart = trigger_pulse && (state != IDLE);
  assign overrun = 1'b0;
`else
  assign restart = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overrun <= 1'b0;
    else if (trigger_pulse && state != IDLE)
      overrun <= 1'b1;
  end
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    burst_nx = burst;
    finish   = 1'b0;
    unique case (state)
      IDLE: begin
        if (trigger_pulse) begin
          state_nx = HIGH;
          cnt_nx   = eff_width - CNT_ONE;
          burst_nx = eff_count - BURST_ONE;
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          if (burst == '0) begin
            state_nx = IDLE;
            finish   = 1'b1;
          end else begin
            state_nx = LOW;
            cnt_nx   = sh_gap - CNT_ONE;
            burst_nx = burst - BURST_ONE;
          end
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      LOW: begin
        if (cnt == '0) begin
          state_nx = HIGH;
          cnt_nx   = sh_width - CNT_ONE;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A restart overrides whatever the running burst was about to do, including finishing.
    if (restart) begin
      state_nx = HIGH;
      cnt_nx   = sh_width - CNT_ONE;
      burst_nx = sh_count - BURST_ONE;
      finish   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      burst       <= '0;
      trigger_out <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      burst       <= burst_nx;
      trigger_out <= (state_nx == HIGH);
      busy        <= (state_nx != IDLE);
      done        <= finish;
    end
  end

  // Config arriving mid-burst is parked and only takes effect when the burst ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_width   <= CNT_ONE;
      sh_gap     <= CNT_ONE;
      sh_count   <= BURST_ONE;
      pend       <= 1'b0;
      pend_width <= CNT_ONE;
      pend_gap   <= CNT_ONE;
      pend_count <= BURST_ONE;
    end else if (state == IDLE) begin
      if (cfg_update) begin
        sh_width <= in_width;
        sh_gap   <= in_gap;
        sh_count <= in_count;
      end
    end else if (finish) begin
      pend <= 1'b0;
      if (cfg_update) begin
        sh_width <= in_width;
        sh_gap   <= in_gap;
        sh_count <= in_count;
      end else if (pend) begin
        sh_width <= pend_width;
        sh_gap   <= pend_gap;
        sh_count <= pend_count;
      end
    end else if (cfg_update) begin
      pend       <= 1'b1;
      pend_width <= in_width;
      pend_gap   <= in_gap;
      pend_count <= in_count;
    end
  end

endmodule

// File: tb/tb_trigger_pulse_gen.sv
// Scoreboard bench for trigger_pulse_gen: a burst-level model predicts every output cycle.
module tb_trigger_pulse_gen;

  localparam int CB = 8;
  localparam int BB = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          trigger_pulse = 1'b0;
  logic [CB-1:0] pulse_width = '0;
  logic [CB-1:0] pulse_gap = '0;
  logic [BB-1:0] pulse_count = '0;
  logic          cfg_update = 1'b0;
  logic          trigger_out, busy, done, overrun;

  trigger_pulse_gen #(.CNT_BITS(CB), .BURST_BITS(BB)) dut (
    .clk(clk), .rst_n(rst_n), .trigger_pulse(trigger_pulse),
    .pulse_width(pulse_width), .pulse_gap(pulse_gap), .pulse_count(pulse_count),
    .cfg_update(cfg_update), .trigger_out(trigger_out), .busy(busy),
    .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {int start; int w; int g; int c; int len;} burst_t;

  burst_t sb[$];
  int     cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  int     sh_w = 1, sh_g = 1, sh_c = 1;
  int     pw = 1, pg = 1, pc = 1;
  bit     pend = 0;
  bit     exp_overrun = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int clamp(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic check_output(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic push_burst(input int k);
    burst_t b;
    b.start = k; b.w = sh_w; b.g = sh_g; b.c = sh_c;
    b.len = sh_c * sh_w + (sh_c - 1) * sh_g;
    sb.push_back(b);
  endtask

  task automatic model_reset();
    sb.delete();
    sh_w = 1; sh_g = 1; sh_c = 1;
    pend = 0;
    exp_overrun = 0;
  endtask

  // Applies the rules to what the DUT sampled at edge k.
  task automatic model_edge(input int k, input bit trig, input bit cfg, input int w, input int g, input int c);
    bit act = 0;
    bit ending;
    int ai = 0;
    foreach (sb[i])
      if (k >= sb[i].start + 1 && k <= sb[i].start + sb[i].len) begin
        act = 1;
        ai = i;
      end
    ending = act && (k == sb[ai].start + sb[ai].len);
    if (!act) begin
      if (cfg) begin sh_w = clamp(w); sh_g = clamp(g); sh_c = clamp(c); end
      if (trig) push_burst(k);
    end else begin
      if (cfg) begin pend = 1; pw = clamp(w); pg = clamp(g); pc = clamp(c); end
      if (trig) begin
`ifdef TRIGGER_PULSE_GEN_RETRIGGER_EN
        sb.delete(ai);
        push_burst(k);
        ending = 0;
`else
        exp_overrun = 1;
`endif
      end
      if (ending && pend) begin
        sh_w = pw; sh_g = pg; sh_c = pc;
        pend = 0;
      end
    end
  endtask

  task automatic apply_stimulus(input bit trig, input bit cfg, input int w, input int g, input int c);
    trigger_pulse = trig;
    cfg_update    = cfg;
    pulse_width   = w[CB-1:0];
    pulse_gap     = g[CB-1:0];
    pulse_count   = c[BB-1:0];
    @(posedge clk);
    #1;
    model_edge(cyc, trig, cfg, w, g, c);
    trigger_pulse = 1'b0;
    cfg_update    = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0);
  endtask

  // Monitor: expected waveform comes from each burst's start cycle and its w/g/c arithmetic.
  always @(negedge clk) begin
    if (rst_n) begin
      logic eo, eb, ed;
      eo = 0; eb = 0; ed = 0;
      foreach (sb[i]) begin
        int p;
        p = cyc - sb[i].start;
        if (p >= 0 && p < sb[i].len) begin
          eb = 1;
          eo = ((p % (sb[i].w + sb[i].g)) < sb[i].w);
        end else if (p == sb[i].len) begin
          ed = 1;
        end
      end
      check_output("trigger_out", trigger_out, eo);
      check_output("busy", busy, eb);
      check_output("done", done, ed);
      check_output("overrun", overrun, exp_overrun);
      while (sb.size() > 0 && cyc >= sb[0].start + sb[0].len) void'(sb.pop_front());
    end
  end

  initial begin
    int k0;
    repeat (3) @(posedge clk);
    #2;
    check_output("reset trigger_out", trigger_out, 1'b0);
    check_output("reset busy", busy, 1'b0);
    check_output("reset done", done, 1'b0);
    check_output("reset overrun", overrun, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(2);

    // Single 4-wide pulse, config and trigger in the same cycle; gap 0 is clamped.
    apply_stimulus(1, 1, 4, 0, 1);
    idle_cycles(7);

    // Three 2-wide pulses separated by 3 low cycles.
    apply_stimulus(0, 1, 2, 3, 3);
    apply_stimulus(1, 0, 0, 0, 0);
    idle_cycles(15);

    // Zero width/count clamp to a single 1-cycle pulse.
    apply_stimulus(1, 1, 0, 2, 0);
    idle_cycles(3);

    // Config update mid-burst only takes effect for the next burst.
    apply_stimulus(1, 1, 3, 2, 2);
    idle_cycles(2);
    apply_stimulus(0, 1, 5, 1, 1);
    idle_cycles(10);
    apply_stimulus(1, 0, 0, 0, 0);
    idle_cycles(8);

    // Trigger during the first HIGH of a 3-pulse burst.
    apply_stimulus(1, 1, 2, 1, 3);
    apply_stimulus(1, 0, 0, 0, 0);
    idle_cycles(12);

    // Reset during a LOW phase, with a pending config that must be discarded.
    apply_stimulus(1, 1, 2, 3, 3);
    apply_stimulus(0, 1, 7, 7, 7);
    idle_cycles(2);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async rst trigger_out", trigger_out, 1'b0);
    check_output("async rst busy", busy, 1'b0);
    check_output("async rst done", done, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(1);
    apply_stimulus(1, 0, 0, 0, 0);
    idle_cycles(4);

    // Maximum width for an 8-bit counter, then a trigger in the done cycle.
    apply_stimulus(1, 1, 255, 1, 1);
    k0 = cyc;
    while (cyc < k0 + 255) apply_stimulus(0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 3, 1, 2);
    idle_cycles(12);

    // Random traffic: short configs, triggers and updates at arbitrary times.
    for (int i = 0; i < 400; i++)
      apply_stimulus(($urandom % 7) == 0, ($urandom % 9) == 0,
                     int'($urandom % 6), int'($urandom % 5), int'($urandom % 4));
    idle_cycles(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
